// File: rtl/dsadc_pkg.sv
// Shared types for the dual-slope ADC counter: controller states and the BCD digit type.
package dsadc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INTEG,
    DEINT,
    DONE
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD timing counter: synchronous clear, increment in, carry out on 9->0.
module bcd_digit
  import dsadc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);

  bcd_t q_q;
  bcd_t q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = (q_q == BCD_MAX) ? bcd_t'(0) : q_q + bcd_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc & ~clr & (q_q == BCD_MAX);

endmodule

// File: rtl/dsadc_contador.sv
// Dual-slope ADC timing counter: times the fixed integration, measures deintegration
// until the integrator crosses zero, and latches the BCD result for the display.
module dsadc_contador
  import dsadc_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_0,
  input  logic                  clr,
  input  logic                  ch_ref,
  input  logic                  vint_z,
  output logic                  en_3,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  valid,
  output logic                  ovf
);

  state_e              state_q, state_d;
  logic                vz_q, vz_d;
  logic                en_3_q, en_3_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;

  logic [4*DIGITS-1:0] count;
  logic                count_inc;
  logic                wrap;
  logic                rise;

  assign rise = vint_z & ~vz_q;

  // The zero crossing takes precedence over counting: the edge that latches the result must not also advance it.
  assign count_inc = en_0 & ~clr &
                     (((state_q == IDLE) & ~ch_ref) |
                      (state_q == INTEG) |
                      ((state_q == DEINT) & ~rise));

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic inc_in;
    logic carry_out;

    if (i == 0) begin : g_first
      assign inc_in = count_inc;
    end else begin : g_next
      assign inc_in = g_digit[i-1].carry_out;
    end

    bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .inc   (inc_in),
      .q     (count[4*i +: 4]),
      .carry (carry_out)
    );
  end

  assign wrap = g_digit[DIGITS-1].carry_out;

  always_comb begin
    state_d = state_q;
    vz_d    = vint_z;
    en_3_d  = 1'b0;
    valid_d = 1'b0;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;

    if (clr) begin
      state_d = IDLE;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_0 && !ch_ref) begin
            state_d = INTEG;
          end
        end
        INTEG: begin
          if (wrap) begin
            en_3_d  = 1'b1;
            state_d = DEINT;
          end
        end
        DEINT: begin
          if (en_0 && rise) begin
            bcd_d   = count;
            valid_d = 1'b1;
            state_d = DONE;
          end else if (wrap) begin
            bcd_d   = {DIGITS{BCD_MAX}};
            ovf_d   = 1'b1;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vz_q    <= 1'b0;
      en_3_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      vz_q    <= vz_d;
      en_3_q  <= en_3_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
    end
  end

  assign en_3  = en_3_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign bcd   = bcd_q;

endmodule

// File: tb/tb_dsadc_contador.sv
// Self-checking bench for dsadc_contador: vector table, hand-written corner sequences
// and random stimulus, all compared every cycle against a decimal reference model.
module tb_dsadc_contador;

  localparam int DIGITS = 3;
  localparam int FULL   = 1000;
  localparam int W      = 4 * DIGITS;

  localparam int PH_IDLE  = 0;
  localparam int PH_INTEG = 1;
  localparam int PH_DEINT = 2;
  localparam int PH_DONE  = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         en_0;
  logic         clr;
  logic         ch_ref;
  logic         vint_z;
  logic         en_3;
  logic [W-1:0] bcd;
  logic         valid;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  // Reference model: the conversion expressed as a decimal count and a phase.
  int m_phase;
  int m_count;
  int m_result;
  bit m_vz_prev;
  bit m_en3;
  bit m_valid;
  bit m_ovf;

  bit seen_valid;
  bit seen_en3;

  dsadc_contador #(.DIGITS(DIGITS)) dut (
    .clk    (clk),
    .reset  (reset),
    .en_0   (en_0),
    .clr    (clr),
    .ch_ref (ch_ref),
    .vint_z (vint_z),
    .en_3   (en_3),
    .bcd    (bcd),
    .valid  (valid),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en_0;
    logic         clr;
    logic         ch_ref;
    logic         vint_z;
    int           cycles;
    logic         exp_en_3;
    logic         exp_valid;
    logic         exp_ovf;
    logic [W-1:0] exp_bcd;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int rem;
    r   = '0;
    rem = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_phase   = PH_IDLE;
    m_count   = 0;
    m_result  = 0;
    m_vz_prev = 1'b0;
    m_en3     = 1'b0;
    m_valid   = 1'b0;
    m_ovf     = 1'b0;
  endtask

  task automatic model_step();
    bit rise;
    rise      = (vint_z === 1'b1) && !m_vz_prev;
    m_vz_prev = (vint_z === 1'b1);
    m_en3     = 1'b0;
    m_valid   = 1'b0;
    if (clr) begin
      m_phase = PH_IDLE;
      m_count = 0;
      m_ovf   = 1'b0;
    end else if (en_0) begin
      case (m_phase)
        PH_IDLE: begin
          if (!ch_ref) begin
            m_phase = PH_INTEG;
            m_count = 1;
          end
        end
        PH_INTEG: begin
          m_count++;
          if (m_count == FULL) begin
            m_count = 0;
            m_en3   = 1'b1;
            m_phase = PH_DEINT;
          end
        end
        PH_DEINT: begin
          if (rise) begin
            m_result = m_count;
            m_valid  = 1'b1;
            m_phase  = PH_DONE;
          end else begin
            m_count++;
            if (m_count == FULL) begin
              m_count  = 0;
              m_result = FULL - 1;
              m_ovf    = 1'b1;
              m_valid  = 1'b1;
              m_phase  = PH_DONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, " en_3"},  W'(en_3),  W'(m_en3));
    check({tag, " valid"}, W'(valid), W'(m_valid));
    check({tag, " ovf"},   W'(ovf),   W'(m_ovf));
    check({tag, " bcd"},   bcd,       to_bcd(m_result));
  endtask

  task automatic checkExpect(input string tag, input logic e3, input logic v,
                             input logic o, input logic [W-1:0] b);
    check({tag, " exp en_3"},  W'(en_3),  W'(e3));
    check({tag, " exp valid"}, W'(valid), W'(v));
    check({tag, " exp ovf"},   W'(ovf),   W'(o));
    check({tag, " exp bcd"},   bcd,       b);
  endtask

  task automatic applyStimulus(input logic e, input logic c, input logic r, input logic z,
                               input int n, input string tag);
    en_0   = e;
    clr    = c;
    ch_ref = r;
    vint_z = z;
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      checkOutput(tag);
      seen_valid |= (valid === 1'b1);
      seen_en3   |= (en_3 === 1'b1);
    end
  endtask

  initial begin
    reset  = 1'b1;
    en_0   = 1'b0;
    clr    = 1'b0;
    ch_ref = 1'b0;
    vint_z = 1'b0;
    model_reset();
    #3;
    checkOutput("reset");
    checkExpect("reset", 1'b0, 1'b0, 1'b0, 12'h000);
    #9;
    reset = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0,  999, 1'b0, 1'b0, 1'b0, 12'h000};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0,    1, 1'b1, 1'b0, 1'b0, 12'h000};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0,  437, 1'b0, 1'b0, 1'b0, 12'h000};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1,    1, 1'b0, 1'b1, 1'b0, 12'h437};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1,    5, 1'b0, 1'b0, 1'b0, 12'h437};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0,    1, 1'b0, 1'b0, 1'b0, 12'h437};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1000, 1'b1, 1'b0, 1'b0, 12'h437};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1000, 1'b0, 1'b1, 1'b1, 12'h999};
    vecs[8] = '{1'b1, 1'b0, 1'b1, 1'b0,    1, 1'b0, 1'b0, 1'b1, 12'h999};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b0,    1, 1'b0, 1'b0, 1'b0, 12'h999};

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].en_0, vecs[i].clr, vecs[i].ch_ref, vecs[i].vint_z,
                    vecs[i].cycles, $sformatf("vec%0d", i));
      checkExpect($sformatf("vec%0d", i), vecs[i].exp_en_3, vecs[i].exp_valid,
                  vecs[i].exp_ovf, vecs[i].exp_bcd);
    end

    // clr mid-integration, then a full restart with comparator noise during INTEG
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 500, "integ500");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1, "clr_integ");
    checkExpect("clr_integ", 1'b0, 1'b0, 1'b0, 12'h999);
    seen_valid = 1'b0;
    seen_en3   = 1'b0;
    for (int k = 0; k < 27; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 36, "restart");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1, "integ_vz");
    end
    check("no_valid_in_integ", W'(seen_valid), W'(1'b0));
    check("no_early_en_3", W'(seen_en3), W'(1'b0));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1, "restart_end");
    checkExpect("restart_end", 1'b1, 1'b0, 1'b0, 12'h999);

    // en_0 paused mid-deintegration
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 250, "deint250");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 20, "pause");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 100, "deint_more");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1, "result350");
    checkExpect("result350", 1'b0, 1'b1, 1'b0, 12'h350);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1, "clr_done");

    // zero crossing on the same edge as the wrap: rise wins
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1000, "integ_full");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 999, "deint999");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1, "rise_wrap");
    checkExpect("rise_wrap", 1'b0, 1'b1, 1'b0, 12'h999);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1, "clr_rw");

    // clr coincident with a rise, then with the integration wrap
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1000, "integ_c");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 10, "deint_c");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1, "clr_rise");
    checkExpect("clr_rise", 1'b0, 1'b0, 1'b0, 12'h999);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 999, "integ_w");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1, "clr_wrap");
    checkExpect("clr_wrap", 1'b0, 1'b0, 1'b0, 12'h999);

    // asynchronous reset between clock edges during deintegration
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1000, "integ_r");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 100, "deint_r");
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    checkExpect("async_reset", 1'b0, 1'b0, 1'b0, 12'h000);
    en_0   = 1'b1;
    clr    = 1'b0;
    ch_ref = 1'b0;
    vint_z = 1'b0;
    #2;
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 999, "post_reset");
    checkExpect("post_reset", 1'b0, 1'b0, 1'b0, 12'h000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1, "post_reset_en3");
    checkExpect("post_reset_en3", 1'b1, 1'b0, 1'b0, 12'h000);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic e, c, r, z;
      e = ($urandom_range(0, 7) != 0);
      if (m_phase == PH_DONE) c = ($urandom_range(0, 19) == 0);
      else c = ($urandom_range(0, 1999) == 0);
      if (m_phase == PH_IDLE) r = ($urandom_range(0, 3) == 0);
      else r = 1'b1;
      z = ($urandom_range(0, 599) == 0);
      applyStimulus(e, c, r, z, 1, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsadc_contador.md
Name: dsadc_contador

Overview:
- BCD timing counter and result latch for the dual-slope integrating ADC. It is the datapath end of the control FSM interface.
- Consumes the FSM's count enable (en_0), clear (clr), reference-phase switch (ch_ref) and the integrator zero-crossing comparator (vint_z).
- Produces en_3, the end-of-fixed-integration pulse back to the FSM, plus the latched conversion result for the display.

Parameters:
DIGITS, 3, number of BCD digits; full scale = 10^DIGITS counts.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
en_0  input  1  count enable from FSM
clr  input  1  synchronous clear from FSM (FSM reset output)
ch_ref  input  1  1 = deintegration (reference) phase
vint_z  input  1  integrator-at-zero comparator, level
en_3  output  1  one-cycle pulse: fixed integration period complete
bcd  output  4*DIGITS  latched result, packed BCD, digit 0 in [3:0]
valid  output  1  one-cycle pulse: new result in bcd
ovf  output  1  sticky: deintegration exceeded full scale

Behaviour:
- Reset (async, immediate, no clock needed): count=0, state IDLE, en_3=0, bcd=0, valid=0, ovf=0, vint_z history register=0.
- Counter: DIGITS cascaded BCD digits; increments by 1 on rising clk when en_0=1, clr=0 and state is INTEG or DEINT. Each digit wraps 9->0 with a carry. Wrap of the top digit sets wrap=1 for that cycle.
- vint_z edge detect: vz_q registered each clock. rise = vint_z & ~vz_q. Input is taken as already synchronous.
- States: IDLE, INTEG, DEINT, DONE.
- IDLE:
  - Count held at 0.
  - en_0=1 and ch_ref=0 -> INTEG; the counter increments on the same edge.
- INTEG:
  - On the top-digit wrap (999->000 for DIGITS=3): en_3=1 for exactly that next cycle, count=0, -> DEINT.
  - vint_z and ch_ref are ignored in this state.
- DEINT:
  - On rise: bcd <= current count (pre-increment value; no increment that edge), valid=1 for one cycle, -> DONE.
  - On wrap without rise: bcd <= all 9s, ovf=1, valid=1 for one cycle, -> DONE.
  - rise and wrap on the same edge: rise wins, bcd = all 9s, ovf=0.
- DONE:
  - Count frozen; bcd, ovf held.
  - Leaves only via clr.
- clr: highest synchronous priority in every state.
  - count=0, state IDLE, ovf=0, no en_3, no valid.
  - bcd keeps the last result.
  - clr with a coincident rise or wrap: clr wins, no pulse generated.
- en_0=0 in INTEG or DEINT: count held, state held.
- Latency:
  - en_3 appears the cycle after the edge on which the counter reaches full scale.
  - valid/bcd appear the cycle after vint_z goes high.
- All outputs are registered. en_3 pulse width is one clk, so it spans one falling edge of the FSM.

Decomposition:
- Package dsadc_pkg:
  - state enum (IDLE, INTEG, DEINT, DONE)
  - bcd_t 4-bit digit typedef
  - BCD_MAX=4'd9 constant
- Sub-module bcd_digit:
  - Ports: clk, reset, clr, inc, q[3:0], carry.
  - One digit with sync clear and increment-in/carry-out; instantiated DIGITS times with inc chained from carry.
- Top holds the FSM, edge detect, result latch and flags.

Test Plan:
1. DIGITS=3, reset pulse, then en_0=1, ch_ref=0 held -> en_3 high exactly one cycle, 1000 enabled edges after start; count=000; state DEINT.
2. Continue with ch_ref=1, vint_z raised after 437 DEINT counts -> bcd=12'h437, valid one cycle, ovf=0; count frozen while clr=0.
3. ch_ref=1, vint_z never rises for 1000 counts -> bcd=12'h999, ovf=1, valid one cycle; clr then gives ovf=0, bcd still 12'h999.
4. In INTEG:
   - clr at count 500 -> count 0, IDLE, no en_3.
   - Restart -> en_3 after a full 1000 counts.
   - vint_z pulses during INTEG -> no valid.
5. en_0 dropped for 20 cycles mid-DEINT at count 250, then restored, vint_z after 100 more counts -> bcd=12'h350.
6. Async reset asserted mid-DEINT between clock edges -> all outputs 0 immediately, before the next edge; after release, a full conversion behaves as scenario 1.
